// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters.
// Define SHIFT_ERR_CNT_EN to add a saturating illegal-op counter on err_cnt.
module shift_req_arbiter #(
    parameter int m = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [m-1:0] req0_a,
    input  logic [4:0]   req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [m-1:0] req1_a,
    input  logic [4:0]   req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [m-1:0] rsp_y,
    output logic         rsp_err,
    output logic [m-1:0] sh_a,
    output logic [m-1:0] sh_b,
    output logic [1:0]   sh_cntrl,
`ifdef SHIFT_ERR_CNT_EN
    output logic [7:0]   err_cnt,
`endif
    input  logic [m-1:0] sh_y
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         id_pend_q, id_pend_d;
    logic         err_pend_q, err_pend_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [m-1:0] rsp_y_q, rsp_y_d;
    logic         rsp_err_q, rsp_err_d;
    logic [m-1:0] sh_a_q, sh_a_d;
    logic [m-1:0] sh_b_q, sh_b_d;
    logic [1:0]   sh_cntrl_q, sh_cntrl_d;
`ifdef SHIFT_ERR_CNT_EN
    logic [7:0]   err_cnt_q, err_cnt_d;
`endif

    logic         grant0, grant1, in_idle, accept;
    logic [m-1:0] win_a;
    logic [4:0]   win_b;
    logic [1:0]   win_op;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant1  = req1_valid && (!req0_valid || !last_grant_q);
        grant0  = req0_valid && !grant1;
        in_idle = (state_q == IDLE) && !rst;
        accept  = in_idle && (grant0 || grant1);
        win_a   = grant1 ? req1_a  : req0_a;
        win_b   = grant1 ? req1_b  : req0_b;
        win_op  = grant1 ? req1_op : req0_op;
    end

    assign req0_ready = in_idle && grant0;
    assign req1_ready = in_idle && grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_pend_d    = id_pend_q;
        err_pend_d   = err_pend_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_err_d    = rsp_err_q;
        sh_a_d       = sh_a_q;
        sh_b_d       = sh_b_q;
        sh_cntrl_d   = sh_cntrl_q;
`ifdef SHIFT_ERR_CNT_EN
        err_cnt_d    = err_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_a_d       = win_a;
                    sh_b_d       = {{(m-5){1'b0}}, win_b};
                    // Illegal op still drives a defined shift so sh_y stays known.
                    sh_cntrl_d   = (win_op == 2'b11) ? 2'b01 : win_op;
                    err_pend_d   = (win_op == 2'b11);
                    id_pend_d    = grant1;
                    last_grant_d = grant1;
                    state_d      = ISSUE;
`ifdef SHIFT_ERR_CNT_EN
                    if (win_op == 2'b11 && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
`endif
                end
            end
            ISSUE: begin
                rsp_y_d     = err_pend_q ? '0 : sh_y;
                rsp_err_d   = err_pend_q;
                rsp_id_d    = id_pend_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_pend_q    <= 1'b0;
            err_pend_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b0;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            sh_cntrl_q   <= 2'b01;
`ifdef SHIFT_ERR_CNT_EN
            err_cnt_q    <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_pend_q    <= id_pend_d;
            err_pend_q   <= err_pend_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_err_q    <= rsp_err_d;
            sh_a_q       <= sh_a_d;
            sh_b_q       <= sh_b_d;
            sh_cntrl_q   <= sh_cntrl_d;
`ifdef SHIFT_ERR_CNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign sh_a      = sh_a_q;
    assign sh_b      = sh_b_q;
    assign sh_cntrl  = sh_cntrl_q;
`ifdef SHIFT_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule
